// File: rtl/risc_pkg.sv
// Shared constants, instruction field layout and sequencer state encoding
// for the register-file operand-fetch/writeback path.
package risc_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_ID_W = 4;
    localparam int INSTR_W  = 16;
    localparam int OPC_W    = 4;
    localparam int RET_W    = 16;

    // Instruction layout: [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2
    localparam int OPC_LSB  = 12;
    localparam int DEST_LSB = 8;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_WRITE    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Bundles the instruction, register-file, ALU and status signals of the
// sequencer; master is the sequencer side, slave the surrounding datapath.
interface regfile_sequencer_if;
    import risc_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic                instr_wb;

    logic                rd1;
    logic                rd2;
    logic                wn1;
    logic                wn2;
    logic [REG_ID_W-1:0] reg_id1;
    logic [REG_ID_W-1:0] reg_id2;
    logic [DATA_W-1:0]   write_data1;
    logic [DATA_W-1:0]   write_data2;
    logic [DATA_W-1:0]   read_data1;
    logic [DATA_W-1:0]   read_data2;

    logic                op_valid;
    logic                op_ready;
    logic [OPC_W-1:0]    op_code;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;

    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_data;

    logic [RET_W-1:0]    retired;

    modport master (
        input  instr_valid, instr, instr_wb,
        input  read_data1, read_data2,
        input  op_ready, res_valid, res_data,
        output instr_ready,
        output rd1, rd2, wn1, wn2, reg_id1, reg_id2, write_data1, write_data2,
        output op_valid, op_code, op_a, op_b,
        output res_ready, retired
    );

    modport slave (
        output instr_valid, instr, instr_wb,
        output read_data1, read_data2,
        output op_ready, res_valid, res_data,
        input  instr_ready,
        input  rd1, rd2, wn1, wn2, reg_id1, reg_id2, write_data1, write_data2,
        input  op_valid, op_code, op_a, op_b,
        input  res_ready, retired
    );

endinterface

// File: rtl/regfile_sequencer.sv
// Serialises one instruction at a time through operand fetch, ALU issue,
// result collection and optional writeback on register-file port 1.
module regfile_sequencer
    import risc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    regfile_sequencer_if.master bus
);

    seq_state_e          state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                wb_q, wb_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [RET_W-1:0]    retired_q, retired_d;

    logic                instr_ready_c;
    logic                rd_c;
    logic                wn1_c;
    logic [REG_ID_W-1:0] id1_c;
    logic [REG_ID_W-1:0] id2_c;
    logic [DATA_W-1:0]   wdata1_c;
    logic                op_valid_c;
    logic                res_ready_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            wb_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            wb_q      <= wb_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            res_q     <= res_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        wb_d          = wb_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        res_d         = res_q;
        retired_d     = retired_q;
        instr_ready_c = 1'b0;
        rd_c          = 1'b0;
        wn1_c         = 1'b0;
        id1_c         = '0;
        id2_c         = '0;
        wdata1_c      = '0;
        op_valid_c    = 1'b0;
        res_ready_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                instr_ready_c = 1'b1;
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    wb_d    = bus.instr_wb;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Register file read data is combinational, so operands land this edge.
                rd_c    = 1'b1;
                id1_c   = instr_q[SRC1_LSB +: REG_ID_W];
                id2_c   = instr_q[SRC2_LSB +: REG_ID_W];
                op_a_d  = bus.read_data1;
                op_b_d  = bus.read_data2;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                op_valid_c = 1'b1;
                if (bus.op_ready) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                res_ready_c = 1'b1;
                if (bus.res_valid) begin
                    res_d = bus.res_data;
                    if (wb_q) begin
                        state_d = ST_WRITE;
                    end else begin
                        retired_d = retired_q + 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                wn1_c     = 1'b1;
                id1_c     = instr_q[DEST_LSB +: REG_ID_W];
                wdata1_c  = res_q;
                retired_d = retired_q + 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.instr_ready = instr_ready_c;
    assign bus.rd1         = rd_c;
    assign bus.rd2         = rd_c;
    assign bus.wn1         = wn1_c;
    assign bus.wn2         = 1'b0;
    assign bus.reg_id1     = id1_c;
    assign bus.reg_id2     = id2_c;
    assign bus.write_data1 = wdata1_c;
    assign bus.write_data2 = '0;
    assign bus.op_valid    = op_valid_c;
    assign bus.op_code     = instr_q[OPC_LSB +: OPC_W];
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.res_ready   = res_ready_c;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Drives the sequencer against a small register file and ALU stub, checking
// directed vectors and random instructions against a behavioural model.
module tb_regfile_sequencer;
    import risc_pkg::*;

    typedef struct {
        logic [15:0] instr;
        logic        wb;
        int          opDelay;
        int          resDelay;
        logic        busyNoise;
        logic [15:0] expA;
        logic [15:0] expB;
        logic [15:0] expRes;
        logic [15:0] expDest;
        logic [15:0] expRetired;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] regFile [16];
    logic        preloadEn = 1'b0;
    logic [3:0]  preloadIdx = 4'h0;
    logic [15:0] preloadVal = 16'h0;
    logic [15:0] modelRf [16];
    logic [15:0] modelRetired;
    vec_t        vecs [5];

    regfile_sequencer_if bus();

    regfile_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Environment register file: combinational read, port-1 write on the clock edge.
    assign bus.read_data1 = regFile[bus.reg_id1];
    assign bus.read_data2 = regFile[bus.reg_id2];

    always @(posedge clk) begin
        if (preloadEn) regFile[preloadIdx] <= preloadVal;
        else if (bus.wn1) regFile[bus.reg_id1] <= bus.write_data1;
    end

    always @(negedge clk) begin
        checks++;
        if (((bus.rd1 | bus.rd2) & (bus.wn1 | bus.wn2)) || bus.wn2 || bus.write_data2 != 16'h0) begin
            errors++;
            $display("[TB] FAIL strobe invariant: rd=%b%b wn=%b%b wd2=0x%0h, required no read with write and wn2/wd2 zero at %0t",
                     bus.rd1, bus.rd2, bus.wn1, bus.wn2, bus.write_data2, $time);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] aluRef(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h1:    return a + b;
            4'h2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic preload(input logic [3:0] idx, input logic [15:0] val);
        @(negedge clk);
        preloadEn  = 1'b1;
        preloadIdx = idx;
        preloadVal = val;
        @(negedge clk);
        preloadEn  = 1'b0;
        modelRf[idx] = val;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [3:0] dest;
        logic [3:0] src1;
        logic [3:0] src2;
        dest = v.instr[11:8];
        src1 = v.instr[7:4];
        src2 = v.instr[3:0];

        for (int n = 0; n < 20 && bus.instr_ready !== 1'b1; n++) @(negedge clk);
        checkOutput("idle before accept", 32'(bus.instr_ready), 1);
        bus.instr_valid = 1'b1;
        bus.instr       = v.instr;
        bus.instr_wb    = v.wb;
        @(negedge clk);

        // READ cycle; optionally keep offering a different instruction while busy.
        if (v.busyNoise) begin
            bus.instr    = ~v.instr;
            bus.instr_wb = ~v.wb;
        end else begin
            bus.instr_valid = 1'b0;
        end
        checkOutput("read instr_ready", 32'(bus.instr_ready), 0);
        checkOutput("read strobes", 32'({bus.rd1, bus.rd2, bus.wn1, bus.wn2}), 32'hC);
        checkOutput("read reg_id1", 32'(bus.reg_id1), 32'(src1));
        checkOutput("read reg_id2", 32'(bus.reg_id2), 32'(src2));
        @(negedge clk);

        for (int n = 0; n <= v.opDelay; n++) begin
            checkOutput("issue op_valid", 32'(bus.op_valid), 1);
            checkOutput("issue op_a", 32'(bus.op_a), 32'(v.expA));
            checkOutput("issue op_b", 32'(bus.op_b), 32'(v.expB));
            checkOutput("issue op_code", 32'(bus.op_code), 32'(v.instr[15:12]));
            checkOutput("issue instr_ready", 32'(bus.instr_ready), 0);
            checkOutput("issue strobes", 32'({bus.rd1, bus.rd2, bus.wn1, bus.reg_id1, bus.reg_id2}), 0);
            bus.op_ready = (n == v.opDelay);
            @(negedge clk);
        end
        bus.op_ready    = 1'b0;
        bus.instr_valid = 1'b0;

        for (int m = 0; m <= v.resDelay; m++) begin
            checkOutput("wait res_ready", 32'(bus.res_ready), 1);
            checkOutput("wait op_valid", 32'(bus.op_valid), 0);
            checkOutput("wait wn1", 32'(bus.wn1), 0);
            bus.res_valid = (m == v.resDelay);
            bus.res_data  = (m == v.resDelay) ? v.expRes : ~v.expRes;
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        bus.res_data  = 16'h0;

        if (v.wb) begin
            checkOutput("write strobes", 32'({bus.rd1, bus.rd2, bus.wn1, bus.wn2}), 32'h2);
            checkOutput("write reg_id1", 32'(bus.reg_id1), 32'(dest));
            checkOutput("write data1", 32'(bus.write_data1), 32'(v.expRes));
            checkOutput("write res_ready", 32'(bus.res_ready), 0);
            @(negedge clk);
        end
        checkOutput("idle after retire", 32'(bus.instr_ready), 1);
        checkOutput("idle wn1", 32'(bus.wn1), 0);
        checkOutput("retired", 32'(bus.retired), 32'(v.expRetired));
        checkOutput("regfile dest", 32'(regFile[dest]), 32'(v.expDest));
    endtask

    task automatic randomVec(output vec_t v);
        logic [3:0] dest;
        v.instr     = 16'($urandom);
        v.wb        = 1'($urandom_range(0, 1));
        v.opDelay   = int'($urandom_range(0, 3));
        v.resDelay  = int'($urandom_range(0, 3));
        v.busyNoise = 1'($urandom_range(0, 1));
        dest        = v.instr[11:8];
        v.expA      = modelRf[v.instr[7:4]];
        v.expB      = modelRf[v.instr[3:0]];
        v.expRes    = aluRef(v.instr[15:12], v.expA, v.expB);
        if (v.wb) modelRf[dest] = v.expRes;
        v.expDest    = modelRf[dest];
        modelRetired = modelRetired + 16'd1;
        v.expRetired = modelRetired;
    endtask

    initial begin
        vec_t rv;

        vecs[0] = '{16'h1123, 1'b1, 0, 0, 1'b0, 16'h0005, 16'h0007, 16'h000C, 16'h000C, 16'd1};
        vecs[1] = '{16'h1123, 1'b0, 0, 0, 1'b0, 16'h0005, 16'h0007, 16'h000C, 16'h000C, 16'd2};
        vecs[2] = '{16'h1123, 1'b1, 3, 2, 1'b0, 16'h0005, 16'h0007, 16'h000C, 16'h000C, 16'd3};
        vecs[3] = '{16'h1411, 1'b1, 0, 0, 1'b1, 16'h000C, 16'h000C, 16'h0018, 16'h0018, 16'd4};
        vecs[4] = '{16'h2442, 1'b1, 0, 0, 1'b1, 16'h0018, 16'h0005, 16'h0013, 16'h0013, 16'd5};

        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0;
        bus.instr_wb    = 1'b0;
        bus.op_ready    = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_data    = 16'h0;
        modelRetired    = 16'h0;

        for (int i = 0; i < 16; i++) begin
            if (i == 2)                preload(4'(i), 16'h0005);
            else if (i == 3)           preload(4'(i), 16'h0007);
            else if (i == 1 || i == 4) preload(4'(i), 16'h0000);
            else                       preload(4'(i), 16'($urandom));
        end

        checkOutput("reset instr_ready", 32'(bus.instr_ready), 1);
        checkOutput("reset op_valid", 32'(bus.op_valid), 0);
        checkOutput("reset res_ready", 32'(bus.res_ready), 0);
        checkOutput("reset op_a", 32'(bus.op_a), 0);
        checkOutput("reset op_b", 32'(bus.op_b), 0);
        checkOutput("reset op_code", 32'(bus.op_code), 0);
        checkOutput("reset retired", 32'(bus.retired), 0);
        checkOutput("reset write_data1", 32'(bus.write_data1), 0);
        checkOutput("reset strobes", 32'({bus.rd1, bus.rd2, bus.wn1, bus.wn2, bus.reg_id1, bus.reg_id2}), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].wb)
                modelRf[vecs[i].instr[11:8]] = aluRef(vecs[i].instr[15:12],
                                                      modelRf[vecs[i].instr[7:4]],
                                                      modelRf[vecs[i].instr[3:0]]);
            modelRetired = modelRetired + 16'd1;
        end

        // Abandon an instruction in WAIT_RES with reset.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h1123;
        bus.instr_wb    = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.op_ready    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.op_ready = 1'b0;
        checkOutput("pre-reset res_ready", 32'(bus.res_ready), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset instr_ready", 32'(bus.instr_ready), 1);
        checkOutput("midreset res_ready", 32'(bus.res_ready), 0);
        checkOutput("midreset strobes", 32'({bus.rd1, bus.rd2, bus.wn1, bus.wn2}), 0);
        checkOutput("midreset retired", 32'(bus.retired), 0);
        @(negedge clk);
        reset        = 1'b0;
        modelRetired = 16'h0;
        repeat (2) @(negedge clk);
        checkOutput("dest after reset", 32'(regFile[1]), 32'(modelRf[1]));
        checkOutput("retired after reset", 32'(bus.retired), 0);

        for (int i = 0; i < 40; i++) begin
            randomVec(rv);
            applyStimulus(rv);
        end

        // Counter wrap: jump the retired count to its maximum.
        @(negedge clk);
        force dut.retired_q = 16'hFFFF;
        @(negedge clk);
        release dut.retired_q;
        checkOutput("retired preset", 32'(bus.retired), 32'hFFFF);
        modelRetired = 16'hFFFF;
        randomVec(rv);
        applyStimulus(rv);
        checkOutput("retired wrap", 32'(bus.retired), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
